// File: rtl/alu_operand_loader_pkg.sv
// Shared types and widths for the ALU operand loader.
// Holds the loader state encoding exposed on the stage output.
package alu_loader_pkg;

    localparam int DATA_W          = 8;
    localparam int OPCODE_W        = 4;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        WAIT_A  = 2'b00,
        WAIT_B  = 2'b01,
        WAIT_OP = 2'b10,
        ISSUE   = 2'b11
    } state_e;

endpackage

// File: rtl/alu_operand_loader_if.sv
// Byte-in / operation-out bus of the ALU operand loader.
// The loader sits on the slave side; its driver uses master.
interface alu_operand_loader_if;
    import alu_loader_pkg::*;

    logic [DATA_W-1:0]   data_in;
    logic                load;
    logic                alu_ready;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [OPCODE_W-1:0] opcode;
    logic                op_valid;
    logic [1:0]          stage;
    logic                overrun;
    logic                bad_op;
    logic                timeout;

    modport master (
        output data_in, load, alu_ready,
        input  op_a, op_b, opcode, op_valid, stage,
        input  overrun, bad_op, timeout
    );

    modport slave (
        input  data_in, load, alu_ready,
        output op_a, op_b, opcode, op_valid, stage,
        output overrun, bad_op, timeout
    );

endinterface

// File: rtl/alu_operand_loader_wdt.sv
// Idle-cycle watchdog for the operand loader byte gaps.
// expired is combinational so the abort lands on the Nth idle edge.
module alu_loader_wdt #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic run,
    input  logic kick,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_cnt;

    assign expired = run && !kick && (r_cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (ena) begin
            if (!run || kick || expired) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/alu_operand_loader.sv
// Collects op_a, op_b and opcode bytes and issues them to the ALU.
// Define LOADER_TIMEOUT_EN to abort stalled sequences via a watchdog.
module alu_operand_loader
    import alu_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    alu_operand_loader_if.slave  bus
);

    state_e              r_state;
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic [OPCODE_W-1:0] r_opcode;
    logic                r_op_valid;
    logic                r_overrun;
    logic                r_bad_op;
    logic                w_op_ok;

    assign w_op_ok = (bus.data_in[7:4] == 4'h0);

`ifdef LOADER_TIMEOUT_EN
    logic r_timeout;
    logic w_run;
    logic w_expired;

    assign w_run = (r_state == WAIT_B) || (r_state == WAIT_OP);

    alu_loader_wdt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdt (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .run     (w_run),
        .kick    (bus.load),
        .expired (w_expired)
    );

    assign bus.timeout = r_timeout;
`else
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= WAIT_A;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_opcode   <= '0;
            r_op_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_bad_op   <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            r_timeout  <= 1'b0;
`endif
        end else if (ena) begin
            unique case (r_state)
                WAIT_A: begin
                    if (bus.load) begin
                        r_op_a  <= bus.data_in;
                        r_state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (bus.load) begin
                        r_op_b  <= bus.data_in;
                        r_state <= WAIT_OP;
                    end
`ifdef LOADER_TIMEOUT_EN
                    else if (w_expired) begin
                        r_timeout <= 1'b1;
                        r_state   <= WAIT_A;
                    end
`endif
                end
                WAIT_OP: begin
                    if (bus.load && w_op_ok) begin
                        r_opcode   <= bus.data_in[OPCODE_W-1:0];
                        r_op_valid <= 1'b1;
                        r_state    <= ISSUE;
                    end else if (bus.load) begin
                        r_bad_op <= 1'b1;
                        r_state  <= WAIT_A;
                    end
`ifdef LOADER_TIMEOUT_EN
                    else if (w_expired) begin
                        r_timeout <= 1'b1;
                        r_state   <= WAIT_A;
                    end
`endif
                end
                ISSUE: begin
                    // a byte arriving with the handshake starts the next op
                    if (bus.alu_ready) begin
                        r_op_valid <= 1'b0;
                        if (bus.load) begin
                            r_op_a  <= bus.data_in;
                            r_state <= WAIT_B;
                        end else begin
                            r_state <= WAIT_A;
                        end
                    end else if (bus.load) begin
                        r_overrun <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.op_a     = r_op_a;
    assign bus.op_b     = r_op_b;
    assign bus.opcode   = r_opcode;
    assign bus.op_valid = r_op_valid;
    assign bus.stage    = r_state;
    assign bus.overrun  = r_overrun;
    assign bus.bad_op   = r_bad_op;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader (directed + random).
// Honours LOADER_TIMEOUT_EN the same way the design does.
module tb_alu_operand_loader;

    localparam int TO = 4;
`ifdef LOADER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic ena;

    alu_operand_loader_if bus();

    alu_operand_loader #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: count of bytes accepted so far (3 = issuing)
    int         m_n;
    int         m_idle;
    logic [7:0] m_a, m_b;
    logic [3:0] m_op;
    bit         m_ovr, m_bad, m_to;

    task automatic model_step(input bit e, r, l, input logic [7:0] d, input bit k);
        if (!r) begin
            m_n = 0; m_idle = 0; m_a = 0; m_b = 0; m_op = 0;
            m_ovr = 0; m_bad = 0; m_to = 0;
        end else if (e) begin
            if (m_n == 3) begin
                m_idle = 0;
                if (k) begin
                    m_n = 0;
                    if (l) begin m_a = d; m_n = 1; end
                end else if (l) begin
                    m_ovr = 1;
                end
            end else if (l) begin
                m_idle = 0;
                if (m_n == 0) begin m_a = d; m_n = 1; end
                else if (m_n == 1) begin m_b = d; m_n = 2; end
                else if (d > 8'h0F) begin m_bad = 1; m_n = 0; end
                else begin m_op = d[3:0]; m_n = 3; end
            end else if (m_n > 0 && TO_EN) begin
                m_idle++;
                if (m_idle == TO) begin m_to = 1; m_n = 0; m_idle = 0; end
            end
        end
    endtask

    function automatic logic [25:0] m_snap();
        logic [1:0] st;
        st = 2'(m_n);
        return {st, (m_n == 3), m_a, m_b, m_op, m_ovr, m_bad, m_to};
    endfunction

    function automatic logic [25:0] dut_snap();
        return {bus.stage, bus.op_valid, bus.op_a, bus.op_b, bus.opcode,
                bus.overrun, bus.bad_op, bus.timeout};
    endfunction

    task automatic drive(input bit e, r, l, input logic [7:0] d, input bit k);
        ena           = e;
        rst_n         = r;
        bus.load      = l;
        bus.data_in   = d;
        bus.alu_ready = k;
        model_step(e, r, l, d, k);
        @(posedge clk);
        #1;
    endtask

    task automatic load3(input logic [7:0] a, b, op, input bit k);
        drive(1, 1, 1, a, k);
        drive(1, 1, 1, b, k);
        drive(1, 1, 1, op, k);
    endtask

    task automatic test_reset();
        drive(1, 0, 1, 8'hFF, 1);
        n_chk++;
        if (dut_snap() !== 26'h0) begin
            n_fail++;
            $display("FAIL reset got %h exp %h", dut_snap(), 26'h0);
        end
    endtask

    task automatic test_basic();
        load3(8'h12, 8'h34, 8'h03, 1);
        n_chk++;
        if (dut_snap() !== {2'b11, 1'b1, 8'h12, 8'h34, 4'h3, 3'b000}) begin
            n_fail++;
            $display("FAIL basic_issue got %h", dut_snap());
        end
        drive(1, 1, 0, 8'h00, 1);
        n_chk++;
        if (dut_snap() !== {2'b00, 1'b0, 8'h12, 8'h34, 4'h3, 3'b000}) begin
            n_fail++;
            $display("FAIL basic_done got %h", dut_snap());
        end
    endtask

    task automatic test_overrun();
        load3(8'h12, 8'h34, 8'h03, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 8'h00, 0);
            n_chk++;
            if (dut_snap() !== {2'b11, 1'b1, 8'h12, 8'h34, 4'h3, 3'b000}) begin
                n_fail++;
                $display("FAIL hold_%0d got %h", i, dut_snap());
            end
        end
        drive(1, 1, 1, 8'hFF, 0);
        n_chk++;
        if (dut_snap() !== {2'b11, 1'b1, 8'h12, 8'h34, 4'h3, 3'b100}) begin
            n_fail++;
            $display("FAIL overrun got %h", dut_snap());
        end
        drive(1, 1, 0, 8'h00, 1);
        n_chk++;
        if (dut_snap() !== {2'b00, 1'b0, 8'h12, 8'h34, 4'h3, 3'b100}) begin
            n_fail++;
            $display("FAIL overrun_release got %h", dut_snap());
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 0, 8'h00, 0);
        load3(8'h12, 8'h34, 8'h03, 0);
        drive(1, 1, 1, 8'h55, 1);
        n_chk++;
        if (dut_snap() !== {2'b01, 1'b0, 8'h55, 8'h34, 4'h3, 3'b000}) begin
            n_fail++;
            $display("FAIL back_to_back got %h", dut_snap());
        end
    endtask

    task automatic test_bad_op();
        drive(1, 0, 0, 8'h00, 0);
        load3(8'h11, 8'h22, 8'h13, 1);
        n_chk++;
        if (dut_snap() !== {2'b00, 1'b0, 8'h11, 8'h22, 4'h0, 3'b010}) begin
            n_fail++;
            $display("FAIL bad_op got %h", dut_snap());
        end
        drive(1, 1, 0, 8'h00, 1);
        n_chk++;
        if (bus.op_valid !== 1'b0 || bus.bad_op !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_op_after valid %b bad %b exp 0 1",
                     bus.op_valid, bus.bad_op);
        end
    endtask

    task automatic test_timeout();
        drive(1, 0, 0, 8'h00, 0);
        drive(1, 1, 1, 8'hAA, 0);
        if (TO_EN) begin
            for (int i = 0; i < TO - 1; i++) drive(1, 1, 0, 8'h00, 0);
            n_chk++;
            if (dut_snap() !== {2'b01, 1'b0, 8'hAA, 8'h00, 4'h0, 3'b000}) begin
                n_fail++;
                $display("FAIL timeout_early got %h", dut_snap());
            end
            drive(1, 1, 0, 8'h00, 0);
            n_chk++;
            if (dut_snap() !== {2'b00, 1'b0, 8'hAA, 8'h00, 4'h0, 3'b001}) begin
                n_fail++;
                $display("FAIL timeout_fire got %h", dut_snap());
            end
        end else begin
            for (int i = 0; i < 20; i++) drive(1, 1, 0, 8'h00, 0);
            n_chk++;
            if (dut_snap() !== {2'b01, 1'b0, 8'hAA, 8'h00, 4'h0, 3'b000}) begin
                n_fail++;
                $display("FAIL no_timeout got %h", dut_snap());
            end
        end
    endtask

    task automatic test_ena_reset();
        drive(1, 1, 1, 8'h01, 0);
        drive(1, 1, 1, 8'h02, 0);
        drive(1, 0, 0, 8'h00, 0);
        n_chk++;
        if (dut_snap() !== 26'h0) begin
            n_fail++;
            $display("FAIL reset_wait_op got %h exp 0", dut_snap());
        end
        load3(8'h01, 8'h02, 8'h03, 0);
        drive(1, 0, 1, 8'h09, 0);
        n_chk++;
        if (dut_snap() !== 26'h0) begin
            n_fail++;
            $display("FAIL reset_issue got %h exp 0", dut_snap());
        end
        drive(1, 1, 1, 8'h07, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 8'h99, 1);
            n_chk++;
            if (dut_snap() !== {2'b01, 1'b0, 8'h07, 8'h00, 4'h0, 3'b000}) begin
                n_fail++;
                $display("FAIL ena_hold_%0d got %h", i, dut_snap());
            end
        end
        drive(1, 1, 1, 8'h08, 0);
        n_chk++;
        if (dut_snap() !== {2'b10, 1'b0, 8'h07, 8'h08, 4'h0, 3'b000}) begin
            n_fail++;
            $display("FAIL ena_resume got %h", dut_snap());
        end
        drive(0, 0, 0, 8'h00, 0);
        n_chk++;
        if (dut_snap() !== 26'h0) begin
            n_fail++;
            $display("FAIL reset_over_ena got %h exp 0", dut_snap());
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        bit e, r, l, k;
        for (int i = 0; i < 600; i++) begin
            d = 8'($urandom);
            if ($urandom_range(3) != 0) d[7:4] = 4'h0;
            e = ($urandom_range(9) != 0);
            r = ($urandom_range(49) != 0);
            l = ($urandom_range(1) != 0);
            k = ($urandom_range(2) == 0);
            drive(e, r, l, d, k);
            n_chk++;
            if (dut_snap() !== m_snap()) begin
                n_fail++;
                $display("FAIL random_%0d got %h exp %h", i, dut_snap(), m_snap());
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        ena           = 1'b1;
        bus.load      = 1'b0;
        bus.data_in   = 8'h00;
        bus.alu_ready = 1'b0;
        test_reset();
        test_basic();
        test_overrun();
        test_back_to_back();
        test_bad_op();
        test_timeout();
        test_ena_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
